rr_hold_arbiter: RTL and testbench

- Round-robin arbiter with grant hold. Shares one resource among WIDTH requesters.
- Winner selection uses masked and unmasked lowest-set-bit scans.
- The grant is registered and held while the owner keeps requesting, with an optional hold-time limit.
- Sits between requester-facing request lines and the shared datapath's select/mux control.

---
 rtl/arb_pkg.sv | 19 +
 rtl/bitscan.sv | 11 +
 rtl/rr_hold_arbiter.sv | 124 ++++++++++++
 tb/tb_rr_hold_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin hold arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Binary index of a one-hot vector (up to 32 requesters); 0 for an all-zero vector.
    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/bitscan.sv
// Lowest-set-bit isolator: one-hot of the least significant set bit, zero if none.
module bitscan #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] vec,
    output logic [WIDTH-1:0] onehot
);

    assign onehot = vec & (~vec + WIDTH'(1));

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with registered grant held while the owner keeps requesting.
//   state | meaning
//   IDLE  | no grant outstanding, arbitrate on any request
//   BUSY  | grant_id owns the resource until release or hold expiry
module rr_hold_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MAX_HOLD = 0,
    localparam int IDW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] grant,
    output logic             grant_valid,
    output logic [IDW-1:0]   grant_id
);

    localparam int HCW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

    arb_state_e       state_q, state_d;
    logic [WIDTH-1:0] grant_q, grant_d;
    logic             grant_valid_q, grant_valid_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic [IDW-1:0]   last_id_q, last_id_d;
    logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;

    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] masked_oh;
    logic [WIDTH-1:0] raw_oh;
    logic [WIDTH-1:0] winner_oh;
    logic [IDW-1:0]   winner_id;
    logic             owner_req;
    logic             expire;
    logic             rearb;

    always_comb begin
        mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask[i] = (i > int'(last_id_q));
        end
    end

    bitscan #(.WIDTH(WIDTH)) u_scan_masked (
        .vec    (req & mask),
        .onehot (masked_oh)
    );

    bitscan #(.WIDTH(WIDTH)) u_scan_raw (
        .vec    (req),
        .onehot (raw_oh)
    );

    assign winner_oh = (|(req & mask)) ? masked_oh : raw_oh;
    assign winner_id = IDW'(onehot_to_idx(32'(winner_oh)));

    assign owner_req = req[grant_id_q];
    // With MAX_HOLD == 0 the counter never advances, so expiry can never fire.
    assign expire    = (MAX_HOLD != 0) && (hold_cnt_q == HCW'(MAX_HOLD - 1));

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        last_id_d     = last_id_q;
        hold_cnt_d    = hold_cnt_q;
        rearb         = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) rearb = 1'b1;
            end
            BUSY: begin
                if (owner_req && !expire) begin
                    if (MAX_HOLD != 0) hold_cnt_d = hold_cnt_q + HCW'(1);
                end else begin
                    rearb = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rearb) begin
            hold_cnt_d = '0;
            if (|req) begin
                state_d       = BUSY;
                grant_d       = winner_oh;
                grant_valid_d = 1'b1;
                grant_id_d    = winner_id;
                last_id_d     = winner_id;
            end else begin
                state_d       = IDLE;
                grant_d       = '0;
                grant_valid_d = 1'b0;
                grant_id_d    = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            last_id_q     <= IDW'(WIDTH - 1);
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            last_id_q     <= last_id_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Bench for rr_hold_arbiter: unlimited-hold and MAX_HOLD=4 instances share one request bus.
module tb_rr_hold_arbiter;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] req;

    logic [W-1:0] g0, g4;
    logic         v0, v4;
    logic [1:0]   id0, id4;

    int checks;
    int errors;

    int mh    [2];
    int owner [2];
    int last  [2];
    int cnt   [2];

    rr_hold_arbiter #(.WIDTH(W), .MAX_HOLD(0)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (g0),
        .grant_valid (v0),
        .grant_id    (id0)
    );

    rr_hold_arbiter #(.WIDTH(W), .MAX_HOLD(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (g4),
        .grant_valid (v4),
        .grant_id    (id4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Next requester in cyclic order after 'lst', or -1 if nobody requests.
    function automatic int pick(input int lst, input logic [W-1:0] r);
        for (int i = 1; i <= W; i++) begin
            int k;
            k = (lst + i) % W;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_edge(input int c);
        int p;
        if (rst) begin
            owner[c] = -1;
            last[c]  = W - 1;
            cnt[c]   = 0;
        end else if (owner[c] < 0) begin
            p = pick(last[c], req);
            if (p >= 0) begin
                owner[c] = p;
                last[c]  = p;
                cnt[c]   = 0;
            end
        end else if (req[owner[c]] && (mh[c] == 0 || cnt[c] < mh[c] - 1)) begin
            cnt[c] = cnt[c] + 1;
        end else begin
            p = pick(last[c], req);
            owner[c] = p;
            if (p >= 0) last[c] = p;
            cnt[c] = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [W-1:0] eg;
        logic [1:0]   eid;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        for (int c = 0; c < 2; c++) begin
            eg  = (owner[c] < 0) ? '0 : (W'(1) << owner[c]);
            eid = (owner[c] < 0) ? 2'd0 : 2'(owner[c]);
            chk((c == 0) ? "model_grant_h0" : "model_grant_h4", 32'((c == 0) ? g0 : g4), 32'(eg));
            chk((c == 0) ? "model_valid_h0" : "model_valid_h4", 32'((c == 0) ? v0 : v4), 32'(owner[c] >= 0));
            chk((c == 0) ? "model_id_h0" : "model_id_h4", 32'((c == 0) ? id0 : id4), 32'(eid));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mh[0] = 0;
        mh[1] = 4;
        for (int c = 0; c < 2; c++) begin
            owner[c] = -1;
            last[c]  = W - 1;
            cnt[c]   = 0;
        end
        rst = 1'b1;
        req = '0;

        step();
        step();
        chk("reset_grant_h0", 32'(g0), 32'h0);
        chk("reset_valid_h4", 32'(v4), 32'h0);
        chk("reset_id_h0", 32'(id0), 32'h0);

        // Lowest requester wins first; grant held while requesting.
        rst = 1'b0;
        req = 4'b1010;
        step();
        chk("first_grant", 32'(g0), 32'h2);
        chk("first_id", 32'(id0), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("held_grant", 32'(g0), 32'h2);
        end
        req = 4'b1000;
        step();
        chk("release_move_grant", 32'(g0), 32'h8);
        chk("release_move_id", 32'(id0), 32'h3);
        req = 4'b0000;
        step();
        chk("idle_grant", 32'(g0), 32'h0);
        chk("idle_valid", 32'(v0), 32'h0);

        // Rotation: each owner drops its bit one cycle after grant.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1111;
        step();
        chk("rot0_h0", 32'(g0), 32'h1);
        req = 4'b1110;
        step();
        chk("rot1_h0", 32'(g0), 32'h2);
        chk("rot1_h4", 32'(g4), 32'h2);
        req = 4'b1101;
        step();
        chk("rot2_h0", 32'(g0), 32'h4);
        req = 4'b1011;
        step();
        chk("rot3_h0", 32'(g0), 32'h8);
        chk("rot3_valid", 32'(v0), 32'h1);
        req = 4'b0111;
        step();
        chk("rot4_h0", 32'(g0), 32'h1);
        chk("rot4_h4", 32'(g4), 32'h1);

        // Hold limit of 4 alternates two constant requesters.
        rst = 1'b1;
        req = 4'b0000;
        step();
        rst = 1'b0;
        req = 4'b0011;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("hold_limit_h4", 32'(g4), (((i / 4) % 2) == 0) ? 32'h1 : 32'h2);
            chk("hold_unlim_h0", 32'(g0), 32'h1);
        end

        // Sole requester survives expiry without a gap.
        req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("sole_grant_h4", 32'(g4), 32'h4);
            chk("sole_valid_h4", 32'(v4), 32'h1);
        end

        req = 4'b0000;
        step();
        chk("drop_idle_h4", 32'(g4), 32'h0);
        chk("drop_id_h4", 32'(id4), 32'h0);
        req = 4'b0001;
        step();
        chk("regrant_h4", 32'(g4), 32'h1);

        // Reset mid-hold restores the pointer.
        req = 4'b0100;
        step();
        step();
        chk("pre_rst_grant", 32'(g0), 32'h4);
        rst = 1'b1;
        step();
        chk("mid_rst_grant", 32'(g0), 32'h0);
        chk("mid_rst_valid", 32'(v4), 32'h0);
        rst = 1'b0;
        req = 4'b1100;
        step();
        chk("post_rst_h0", 32'(g0), 32'h4);
        chk("post_rst_h4", 32'(g4), 32'h4);

        // Random traffic against the model, biased toward sticky requests.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 2) == 0) req = W'($urandom_range(0, 15));
            step();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
